// File: rtl/sr_bank_driver_if.sv
// ---------------------------------------------------------------------------
// sr_bank_driver_if
// Bundles the target handshake, the S/R drive lines, the Q readback and the
// status outputs of sr_bank_driver.
//   master : control/bank side. Drives tgt_valid, tgt_data and q_fb, and
//            observes everything else.
//   slave  : sr_bank_driver itself.
// Ports carried:
//   tgt_valid/tgt_ready/tgt_data  target word handshake
//   s, r                          registered set/reset pulses to the bank
//   q_fb                          bank Q readback
//   shadow                        driver's record of the bank state
//   busy, done, err, err_cnt      status
// ---------------------------------------------------------------------------
interface sr_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] shadow;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, s, r, shadow, busy, done, err, err_cnt
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, s, r, shadow, busy, done, err, err_cnt
    );
endinterface

// File: rtl/sr_bank_driver.sv
// ---------------------------------------------------------------------------
// sr_bank_driver
// Drives a bank of SR flip-flops from a target word. For every accepted
// target it issues one registered cycle of S/R pulses that move the bank from
// its recorded state (shadow) to the target. S and R are never high together
// on the same bit. Optionally reads Q back after a settle time and flags any
// mismatch against shadow.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; forces the bank to 0 (r = all ones)
//   bus   sr_bank_driver_if.slave: tgt_valid/tgt_ready/tgt_data handshake,
//         s/r pulses, q_fb readback, shadow, busy, done, err, err_cnt
//
// Parameters:
//   WIDTH   number of flip-flops driven (must match the interface WIDTH)
//   SETTLE  cycles between the pulse and the readback compare (1..15)
//
// Build option:
//   SR_READBACK_CHECK_EN  when defined, adds the SETTLE wait, compares q_fb
//                         against shadow in CHECK and makes err/err_cnt live.
//                         When undefined, DRIVE goes straight to CHECK, q_fb
//                         is ignored and err/err_cnt are tied to 0.
// ---------------------------------------------------------------------------
module sr_bank_driver #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    sr_bank_driver_if.slave bus
);

    typedef enum logic [2:0] {
        ST_CLR    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] r_next;
    logic             accept;
    logic             mismatch;
    logic             tgt_ready_next;
    logic             busy_next;
    logic             done_next;
    logic             err_next;

    // Per-bit pulse: set only bits going 0->1, reset only bits going 1->0.
    // A bit cannot be both, so S and R are mutually exclusive by construction.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pulse
            assign s_next[gi] = bus.tgt_data[gi] & ~shadow_reg[gi];
            assign r_next[gi] = ~bus.tgt_data[gi] & shadow_reg[gi];
        end
    endgenerate

    // tgt_ready is a pure function of state, so accept has no loop back
    // through the ready output.
    assign accept = (state_reg == ST_IDLE) && bus.tgt_valid;

`ifdef SR_READBACK_CHECK_EN
    logic [3:0] settle_cnt_reg;
    logic [7:0] err_cnt_reg;

    assign mismatch = (bus.q_fb != shadow_reg);
`else
    logic unused_q_fb;

    assign unused_q_fb = ^bus.q_fb;
    assign mismatch    = 1'b0;
`endif

    // Next state and state-decoded outputs.
    always_comb begin
        state_next     = state_reg;
        tgt_ready_next = 1'b0;
        busy_next      = 1'b1;
        done_next      = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            ST_CLR: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                tgt_ready_next = 1'b1;
                busy_next      = 1'b0;
                if (bus.tgt_valid) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
`ifdef SR_READBACK_CHECK_EN
                state_next = ST_SETTLE;
`else
                state_next = ST_CHECK;
`endif
            end
            ST_SETTLE: begin
`ifdef SR_READBACK_CHECK_EN
                if (settle_cnt_reg == 4'd0) begin
                    state_next = ST_CHECK;
                end
`else
                state_next = ST_CHECK;
`endif
            end
            ST_CHECK: begin
                done_next  = 1'b1;
                err_next   = mismatch;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_CLR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Hold the bank cleared for as long as reset is asserted.
            state_reg  <= ST_CLR;
            s_reg      <= '0;
            r_reg      <= '1;
            shadow_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Pulses live for exactly the DRIVE cycle; zero everywhere else.
            s_reg     <= accept ? s_next : '0;
            r_reg     <= accept ? r_next : '0;
            if (accept) begin
                shadow_reg <= bus.tgt_data;
            end
        end
    end

`ifdef SR_READBACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_reg <= 4'd0;
            err_cnt_reg    <= 8'd0;
        end else begin
            // Loaded in DRIVE so SETTLE lasts exactly SETTLE cycles (N-1..0).
            if (state_reg == ST_DRIVE) begin
                settle_cnt_reg <= 4'(SETTLE - 1);
            end else if ((state_reg == ST_SETTLE) && (settle_cnt_reg != 4'd0)) begin
                settle_cnt_reg <= settle_cnt_reg - 4'd1;
            end
            if ((state_reg == ST_CHECK) && mismatch && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.err_cnt = err_cnt_reg;
`else
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.s         = s_reg;
    assign bus.r         = r_reg;
    assign bus.shadow    = shadow_reg;
    assign bus.tgt_ready = tgt_ready_next;
    assign bus.busy      = busy_next;
    assign bus.done      = done_next;
    assign bus.err       = err_next;

endmodule

// File: tb/tb_sr_bank_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_bank_driver
// Directed checks of sr_bank_driver: reset behaviour, pulse generation,
// latency, readback mismatch counting with saturation, reset abort, and a
// random phase checking S/R exclusivity against a behavioural SR bank.
// Works with and without SR_READBACK_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_sr_bank_driver;

    localparam int WIDTH  = 8;
    localparam int SETTLE = 2;
`ifdef SR_READBACK_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int DONE_LAT = CHK_EN ? (2 + SETTLE) : 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sr_bank_driver_if #(.WIDTH(WIDTH)) bus ();

    sr_bank_driver #(
        .WIDTH (WIDTH),
        .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural SR bank driven by the DUT pulses.
    logic [WIDTH-1:0] bank_q = '0;
    always @(posedge clk) begin
        bank_q <= (bank_q | bus.s) & ~bus.r;
    end

    logic             force_q   = 1'b0;
    logic [WIDTH-1:0] force_val = '0;
    assign bus.q_fb = force_q ? force_val : bank_q;

    int         n_chk   = 0;
    int         n_err   = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one target from IDLE and follow it through to the next IDLE.
    task automatic send(input logic [7:0] data, input logic [7:0] es, input logic [7:0] er);
        int   k;
        logic exp_err;
        chk("ready_before", 32'(bus.tgt_ready), 32'd1);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = data;
        tick();
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = ~data;   // later changes must be ignored
        chk("pulse_s", 32'(bus.s), 32'(es));
        chk("pulse_r", 32'(bus.r), 32'(er));
        chk("shadow_upd", 32'(bus.shadow), 32'(data));
        chk("busy_drive", 32'(bus.busy), 32'd1);
        k = 1;
        while (k < 30 && bus.done !== 1'b1) begin
            tick();
            k++;
            if (k == 2) begin
                chk("pulse_off", 32'(bus.s | bus.r), 32'd0);
            end
        end
        chk("done_latency", 32'(k), 32'(DONE_LAT));
        exp_err = CHK_EN && force_q && (force_val != data);
        chk("err_at_done", 32'(bus.err), 32'(exp_err));
        chk("bank_at_done", 32'(bank_q), 32'(data));
        if (exp_err && exp_cnt != 8'hFF) begin
            exp_cnt = exp_cnt + 8'd1;
        end
        tick();
        chk("done_cleared", 32'(bus.done), 32'd0);
        chk("ready_after", 32'(bus.tgt_ready), 32'd1);
        chk("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
        $display("send tgt=%02h s=%02h r=%02h latency=%0d err_cnt=%0d", data, es, er, k, bus.err_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int         n_acc;
    int         n_done;
    logic [7:0] last_acc;

    initial begin
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = '0;
        rst           = 1'b1;

        // Reset for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_r", 32'(bus.r), 32'hFF);
            chk("rst_s", 32'(bus.s), 32'h00);
            chk("rst_ready", 32'(bus.tgt_ready), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd1);
            chk("rst_done", 32'(bus.done), 32'd0);
        end
        chk("rst_shadow", 32'(bus.shadow), 32'h00);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        // First cycle after release: still CLR.
        chk("clr_r", 32'(bus.r), 32'hFF);
        chk("clr_ready", 32'(bus.tgt_ready), 32'd0);
        tick();
        chk("idle_r", 32'(bus.r), 32'h00);
        chk("idle_ready", 32'(bus.tgt_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_shadow", 32'(bus.shadow), 32'h00);
        $display("reset released, idle");

        // Directed pulses.
        send(8'hA5, 8'hA5, 8'h00);
        send(8'h3C, 8'h18, 8'h81);
        send(8'h3C, 8'h00, 8'h00);

        // Readback mismatch and saturation.
        force_q   = 1'b1;
        force_val = 8'h3D;
        send(8'h3C, 8'h00, 8'h00);
        chk("err_cnt_first", 32'(bus.err_cnt), CHK_EN ? 32'd1 : 32'd0);
        for (int i = 0; i < 299; i++) begin
            send(8'h3C, 8'h00, 8'h00);
        end
        chk("err_cnt_sat", 32'(bus.err_cnt), CHK_EN ? 32'd255 : 32'd0);
        force_q = 1'b0;

        // Reset during an operation (SETTLE when checking, DRIVE otherwise).
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 8'hFF;
        tick();
        bus.tgt_valid = 1'b0;
        chk("abort_pulse_s", 32'(bus.s), 32'hC3);
        if (CHK_EN) begin
            tick();
        end
        rst = 1'b1;
        tick();
        chk("abort_r", 32'(bus.r), 32'hFF);
        chk("abort_s", 32'(bus.s), 32'h00);
        chk("abort_shadow", 32'(bus.shadow), 32'h00);
        chk("abort_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("abort_done2", 32'(bus.done), 32'd0);
        rst = 1'b0;
        chk("abort_clr_r", 32'(bus.r), 32'hFF);
        chk("abort_clr_done", 32'(bus.done), 32'd0);
        tick();
        chk("abort_idle", 32'(bus.tgt_ready), 32'd1);
        chk("abort_bank", 32'(bank_q), 32'h00);
        exp_cnt = 8'd0;
        $display("reset abort done");

        // Random targets with random gaps.
        n_acc    = 0;
        n_done   = 0;
        last_acc = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            bus.tgt_valid = ($urandom_range(0, 3) == 0);
            bus.tgt_data  = 8'($urandom);
            if (bus.tgt_valid && bus.tgt_ready) begin
                last_acc = bus.tgt_data;
                n_acc++;
            end
            tick();
            chk("s_and_r", 32'(bus.s & bus.r), 32'd0);
            if (bus.done) begin
                n_done++;
                chk("rand_shadow", 32'(bus.shadow), 32'(last_acc));
                chk("rand_bank", 32'(bank_q), 32'(last_acc));
                chk("rand_err", 32'(bus.err), 32'd0);
            end
        end
        bus.tgt_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.done) begin
                n_done++;
                chk("drain_bank", 32'(bank_q), 32'(last_acc));
            end
        end
        chk("rand_done_count", 32'(n_done), 32'(n_acc));
        chk("rand_err_cnt", 32'(bus.err_cnt), 32'd0);
        $display("random phase: %0d accepts, %0d done pulses", n_acc, n_done);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_bank_driver.md
# sr_bank_driver

Excitation-side controller for a bank of SR flip-flops: accepts a target word over a valid/ready handshake and generates the per-bit S/R pulses that move the bank from its current state to the target. It never issues the forbidden S=R=1 combination. It optionally reads the bank's Q outputs back and flags mismatches. It sits between control logic that decides *what* state is wanted and the SR flip-flop bank that stores it.

## Interface
- WIDTH, 8, number of SR flip-flops driven.
- SETTLE, 2, idle cycles after a drive pulse before readback compare; legal range 1..15.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- tgt_valid  in  1  target word offered
- tgt_data  in  WIDTH  desired bank state
- tgt_ready  out  1  block can accept a target
- s  out  WIDTH  set pulses to bank, registered
- r  out  WIDTH  reset pulses to bank, registered
- q_fb  in  WIDTH  bank Q readback; ignored when check disabled
- shadow  out  WIDTH  block's record of bank state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: update complete
- err  out  1  one-cycle pulse with done: readback mismatch
- err_cnt  out  8  saturating mismatch count

## Operation
- States: CLR, IDLE, DRIVE, SETTLE, CHECK.
- **CLR**
  - Entered while rst is high.
  - r = all ones and s = 0, so the bank is forced to 0; shadow = 0.
  - Stays in CLR for exactly one cycle after rst falls, then goes to IDLE.
- **IDLE**
  - tgt_ready = 1; s = r = 0.
  - On tgt_valid & tgt_ready, register the next drive pulses: s <= tgt_data & ~shadow, r <= ~tgt_data & shadow, shadow <= tgt_data. Go to DRIVE.
- **DRIVE**
  - Lasts one cycle; s/r hold the pulse computed on entry.
  - Bits where target equals shadow get s = r = 0 (hold). A target equal to shadow still passes through DRIVE, giving an all-zero pulse and the same latency.
  - With the check enabled, go to SETTLE; otherwise go to CHECK.
- **SETTLE**
  - s = r = 0; a counter runs for SETTLE cycles, then the block goes to CHECK.
- **CHECK**
  - Lasts one cycle; done = 1.
  - With the check enabled, q_fb is compared to shadow. On mismatch, err = 1 and err_cnt increments, saturating at 255.
  - Next state is IDLE.
- Invariant: (s & r) == 0 in every cycle, including during reset.
- Reset in any state aborts the operation and returns to CLR.
  - An in-flight target is dropped; shadow and err_cnt return to 0.
  - No done pulse is produced for the aborted operation.
- tgt_data is sampled only in the accept cycle; later changes have no effect.

## Timing
- Reset values: s = 0, r = all ones, tgt_ready = 0, busy = 1, done = 0, err = 0, err_cnt = 0, shadow = 0.
- Taking the accept cycle as N:
  - s/r pulse is visible in cycle N+1 only.
  - shadow updates at N+1.
  - Check enabled: done (and err if applicable) in cycle N+2+SETTLE; tgt_ready high again at N+3+SETTLE.
  - Check disabled: done in cycle N+2; tgt_ready high again at N+3.
- Minimum spacing between accepts: SETTLE+3 cycles with the check enabled, 3 cycles without.
- tgt_ready depends only on state, never on tgt_valid, so there is no combinational path from tgt_valid to tgt_ready.
- q_fb is sampled on the rising edge that ends the CHECK cycle. The bank must present Q within SETTLE cycles of the pulse.

## Configuration
- Macro: SR_READBACK_CHECK_EN.
- Defined:
  - SETTLE state and counter are present.
  - q_fb is compared in CHECK.
  - err and err_cnt are live.
- Undefined:
  - SETTLE is bypassed (DRIVE goes straight to CHECK).
  - q_fb is unused.
  - err and err_cnt are tied to 0.
  - Latency is as given for the disabled case in Timing.

## Test plan
- Reset for 3 cycles, then release:
  - r = 0xFF throughout reset and for one cycle after release, then r = 0.
  - tgt_ready rises on the 2nd cycle after release.
  - shadow = 0x00.
- From shadow 0x00, accept 0xA5 → s = 0xA5, r = 0x00 for one cycle; shadow = 0xA5; done in cycle N+4 (SETTLE = 2, check enabled) or N+2 (check disabled).
- From shadow 0xA5, accept 0x3C → s = 0x18, r = 0x81; then accept 0x3C again → s = r = 0x00 with identical latency.
- With the check enabled, force q_fb = 0x3D when shadow = 0x3C → err pulses together with done; err_cnt = 1. Repeat 300 mismatches → err_cnt holds at 255.
- Assert rst during SETTLE → no done pulse; state returns to CLR; shadow = 0 and err_cnt = 0; r = 0xFF.
- Random targets with random tgt_valid gaps over 10k cycles → (s & r) is never nonzero. A bench SR model driven by s/r always matches shadow at done.
